send_scheduler: RTL

SEND_SCHEDULER -- requirements
Module: send_scheduler

---
 rtl/send_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/send_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : send_scheduler
//  Purpose  : Merges two one-pulse message requesters into a circular FIFO
//             (round-robin on conflicts) and dispatches entries one at a time
//             to the interboard sender with ctrl_en handshake, retry on
//             non-acceptance and an enforced idle gap between transactions.
//  Revision : 1.0  initial release
// ============================================================================
module send_scheduler #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a_en,
  input  logic [21:0] req_a_msg,
  input  logic        req_b_en,
  input  logic [21:0] req_b_msg,
  input  logic        send_idle,
  output logic        ctrl_en,
  output logic [3:0]  ctrl_msg_type,
  output logic [4:0]  ctrl_block_x,
  output logic [2:0]  ctrl_block_y,
  output logic [5:0]  ctrl_card,
  output logic [2:0]  ctrl_sel_len,
  output logic        ctrl_move_dir,
  output logic [4:0]  q_count,
  output logic        overflow,
  output logic        busy
);

  localparam int         c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] c_DEPTH    = 6'(DEPTH);
  localparam logic [3:0] c_GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [2:0] c_RETRY_LAST = 3'd7;

  localparam logic [2:0] c_S_IDLE        = 3'd0;
  localparam logic [2:0] c_S_ISSUE       = 3'd1;
  localparam logic [2:0] c_S_WAIT_ACCEPT = 3'd2;
  localparam logic [2:0] c_S_WAIT_DONE   = 3'd3;
  localparam logic [2:0] c_S_GAP_WAIT    = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [21:0]     r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW-1:0] w_wr_ptr1;
  logic [4:0]      r_count;
  logic            r_rr;          // 0: A wins the next conflict, 1: B wins
  logic [3:0]      r_gap_cnt;
  logic [2:0]      r_retry_cnt;
  logic            r_overflow;
  logic [21:0]     r_msg;

  logic            w_pop;
  logic [5:0]      w_space;
  logic            w_push0;
  logic            w_push1;
  logic [21:0]     w_data0;
  logic [21:0]     w_data1;
  logic            w_drop;
  logic [1:0]      w_n_push;

  // The head leaves the FIFO in the same cycle the FSM moves IDLE->ISSUE,
  // so that slot already counts as free for this cycle's pushes.
  assign w_pop     = (r_state == c_S_IDLE) && (r_count != 5'd0) && send_idle;
  assign w_space   = c_DEPTH - {1'b0, r_count} + {5'b0, w_pop};
  assign w_wr_ptr1 = r_wr_ptr + c_AW'(1);
  assign w_n_push  = {1'b0, w_push0} + {1'b0, w_push1};

  // Decide which requests are written, in which order, and which are dropped
  always_comb begin
    w_push0 = 1'b0;
    w_push1 = 1'b0;
    w_data0 = req_a_msg;
    w_data1 = req_b_msg;
    w_drop  = 1'b0;
    if (req_a_en && req_b_en) begin
      if (r_rr) begin
        w_data0 = req_b_msg;
        w_data1 = req_a_msg;
      end
      w_push0 = (w_space >= 6'd1);
      w_push1 = (w_space >= 6'd2);
      w_drop  = (w_space <  6'd2);
    end else if (req_a_en) begin
      w_push0 = (w_space != 6'd0);
      w_data0 = req_a_msg;
      w_drop  = (w_space == 6'd0);
    end else if (req_b_en) begin
      w_push0 = (w_space != 6'd0);
      w_data0 = req_b_msg;
      w_drop  = (w_space == 6'd0);
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (rst && w_push0) r_mem[r_wr_ptr]  <= w_data0;
    if (rst && w_push1) r_mem[w_wr_ptr1] <= w_data1;
  end

  // FIFO pointers, occupancy, sticky overflow and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 5'd0;
      r_overflow <= 1'b0;
      r_rr       <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + c_AW'(w_n_push);
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      r_count <= r_count + {3'b0, w_n_push} - {4'b0, w_pop};
      if (w_drop) r_overflow <= 1'b1;
      if (req_a_en && req_b_en) r_rr <= ~r_rr;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= c_S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:        if (w_pop) w_state_nxt = c_S_ISSUE;
      c_S_ISSUE:       w_state_nxt = c_S_WAIT_ACCEPT;
      c_S_WAIT_ACCEPT: begin
        if (!send_idle)                       w_state_nxt = c_S_WAIT_DONE;
        else if (r_retry_cnt == c_RETRY_LAST) w_state_nxt = c_S_ISSUE;
      end
      // With no gap configured the sender completion returns straight to IDLE
      c_S_WAIT_DONE:   if (send_idle) w_state_nxt = (GAP == 0) ? c_S_IDLE : c_S_GAP_WAIT;
      c_S_GAP_WAIT:    if (r_gap_cnt == c_GAP_LAST) w_state_nxt = c_S_IDLE;
      default:         w_state_nxt = c_S_IDLE;
    endcase
  end

  // Cycle counters for the accept timeout and the inter-transaction gap
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_retry_cnt <= 3'd0;
      r_gap_cnt   <= 4'd0;
    end else begin
      r_retry_cnt <= (r_state == c_S_WAIT_ACCEPT) ? r_retry_cnt + 3'd1 : 3'd0;
      r_gap_cnt   <= (r_state == c_S_GAP_WAIT)    ? r_gap_cnt + 4'd1   : 4'd0;
    end
  end

  // Dispatched message fields, loaded only when an entry leaves the FIFO
  always_ff @(posedge clk) begin
    if (!rst)       r_msg <= 22'd0;
    else if (w_pop) r_msg <= r_mem[r_rd_ptr];
  end

  // FSM outputs; the pulse is masked if the sender is not idle so a start
  // is never issued into a busy sender
  always_comb begin
    ctrl_en = (r_state == c_S_ISSUE) && send_idle;
    busy    = (r_count != 5'd0) || (r_state != c_S_IDLE);
  end

  assign ctrl_msg_type = r_msg[21:18];
  assign ctrl_block_x  = r_msg[17:13];
  assign ctrl_block_y  = r_msg[12:10];
  assign ctrl_card     = r_msg[9:4];
  assign ctrl_sel_len  = r_msg[3:1];
  assign ctrl_move_dir = r_msg[0];
  assign q_count       = r_count;
  assign overflow      = r_overflow;

endmodule
`default_nettype wire
